// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the core's shift units (left iterative shifter and
// the existing combinational right shifter).
//   XLEN          : architectural data width
//   SHAMT_W       : shift-amount width, $clog2(XLEN)
//   shift_state_e : control states of the iterative shifter
// ----------------------------------------------------------------------------
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage : shift_pkg

// File: rtl/shift_left_seq_if.sv
// ----------------------------------------------------------------------------
// shift_left_seq_if
// Request/response bundle of the iterative left shifter.
//   in_valid/in_ready     : request handshake
//   data_in/shift_amount  : request payload
//   flush                 : synchronous abort from the pipeline
//   out_valid/out_ready   : result handshake
//   data_out              : result payload (zero unless a result is presented)
//   busy                  : an operation occupies the unit
// master = requester/consumer side, slave = shifter side.
// ----------------------------------------------------------------------------
interface shift_left_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shift_amount;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;
    logic               busy;

    modport master (
        output in_valid,
        input  in_ready,
        output data_in,
        output shift_amount,
        output flush,
        input  out_valid,
        output out_ready,
        input  data_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  data_in,
        input  shift_amount,
        input  flush,
        output out_valid,
        input  out_ready,
        output data_out,
        output busy
    );

endinterface : shift_left_seq_if

// File: rtl/shift_left_step.sv
// ----------------------------------------------------------------------------
// shift_left_step
// One iteration of the left shifter: shifts the accumulator by
// min(remaining count, STEP) and returns the reduced count.
//   i_acc : current accumulator
//   i_cnt : remaining positions to shift
//   o_acc : accumulator after this iteration (zero-filled from the LSB)
//   o_cnt : remaining positions after this iteration
// ----------------------------------------------------------------------------
module shift_left_step #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0]   i_acc,
    input  logic [SHAMT_W-1:0] i_cnt,
    output logic [WIDTH-1:0]   o_acc,
    output logic [SHAMT_W-1:0] o_cnt
);

    // One extra bit so STEP == WIDTH is representable.
    localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W + 1)'(STEP);

    logic [SHAMT_W:0] w_cnt_ext;
    logic [SHAMT_W:0] w_amt;

    assign w_cnt_ext = {1'b0, i_cnt};
    assign w_amt     = (w_cnt_ext >= STEP_L) ? STEP_L : w_cnt_ext;
    assign o_acc     = i_acc << w_amt;
    // w_amt never exceeds i_cnt, so the count cannot wrap.
    assign o_cnt     = i_cnt - w_amt[SHAMT_W-1:0];

endmodule : shift_left_step

// File: rtl/shift_left_seq.sv
// ----------------------------------------------------------------------------
// shift_left_seq
// Iterative logical left shifter for the SLL/SLLI path of the multi-cycle
// execute unit. Shifts up to STEP positions per cycle; one operation in
// flight at a time.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side), see shift_left_seq_if
// Latency from acceptance to first out_valid: 1 + ceil(shift_amount/STEP).
// ----------------------------------------------------------------------------
module shift_left_seq #(
    parameter int WIDTH   = shift_pkg::XLEN,
    parameter int SHAMT_W = shift_pkg::SHAMT_W,
    parameter int STEP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_left_seq_if.slave   bus
);

    import shift_pkg::*;

    shift_state_e       r_state;
    shift_state_e       w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   w_step_acc;
    logic [SHAMT_W-1:0] w_step_cnt;
    logic               w_accept;

    shift_left_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) u_step (
        .i_acc (r_acc),
        .i_cnt (r_cnt),
        .o_acc (w_step_acc),
        .o_cnt (w_step_cnt)
    );

    // flush masks both handshakes so neither side believes a transfer
    // happened in the abort cycle.
    assign bus.in_ready  = (r_state == IDLE) && !bus.flush;
    assign bus.out_valid = (r_state == DONE) && !bus.flush;
    // Zero outside DONE so the downstream result mux never sees stale data.
    assign bus.data_out  = (r_state == DONE) ? r_acc : '0;
    assign bus.busy      = (r_state != IDLE);

    assign w_accept = bus.in_valid && bus.in_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = (bus.shift_amount == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_step_cnt == '0) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!bus.flush) begin
            if (w_accept) begin
                r_acc <= bus.data_in;
                r_cnt <= bus.shift_amount;
            end else if (r_state == SHIFT) begin
                r_acc <= w_step_acc;
                r_cnt <= w_step_cnt;
            end
        end
    end

endmodule : shift_left_seq

// File: tb/tb_shift_left_seq.sv
// ----------------------------------------------------------------------------
// tb_shift_left_seq
// Drives a STEP=1 and a STEP=4 instance of shift_left_seq with identical
// requests and compares each cycle against a reference built from the
// arithmetic result (data << s) and the expected latency 1+ceil(s/STEP).
// ----------------------------------------------------------------------------
module tb_shift_left_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    shift_left_seq_if #(.WIDTH(32), .SHAMT_W(5)) bus0 ();
    shift_left_seq_if #(.WIDTH(32), .SHAMT_W(5)) bus1 ();

    shift_left_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    shift_left_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Common request drive, per-instance out_ready.
    logic        tb_in_valid;
    logic [31:0] tb_data_in;
    logic [4:0]  tb_shamt;
    logic        tb_flush;
    logic [1:0]  tb_oready;

    assign bus0.in_valid     = tb_in_valid;
    assign bus0.data_in      = tb_data_in;
    assign bus0.shift_amount = tb_shamt;
    assign bus0.flush        = tb_flush;
    assign bus0.out_ready    = tb_oready[0];
    assign bus1.in_valid     = tb_in_valid;
    assign bus1.data_in      = tb_data_in;
    assign bus1.shift_amount = tb_shamt;
    assign bus1.flush        = tb_flush;
    assign bus1.out_ready    = tb_oready[1];

    logic [1:0]  w_ov, w_irdy, w_busy;
    logic [31:0] w_dout [2];

    assign w_ov[0]   = bus0.out_valid;
    assign w_ov[1]   = bus1.out_valid;
    assign w_irdy[0] = bus0.in_ready;
    assign w_irdy[1] = bus1.in_ready;
    assign w_busy[0] = bus0.busy;
    assign w_busy[1] = bus1.busy;
    assign w_dout[0] = bus0.data_out;
    assign w_dout[1] = bus1.data_out;

    int step_of [2] = '{1, 4};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int j = 0; j < 2; j++) begin
            check_eq($sformatf("%s.d%0d.ov", tag, j),   32'(w_ov[j]),   32'd0);
            check_eq($sformatf("%s.d%0d.busy", tag, j), 32'(w_busy[j]), 32'd0);
            check_eq($sformatf("%s.d%0d.irdy", tag, j), 32'(w_irdy[j]), 32'd1);
            check_eq($sformatf("%s.d%0d.dout", tag, j), w_dout[j],      32'd0);
        end
    endtask

    // Issue one request to both instances; hold out_ready low for h cycles
    // after the result appears, then check every cycle until both return idle.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s, input int h);
        int          lat [2];
        bit          fin [2];
        logic [31:0] res;
        bit          exp_ov;
        int          n;
        res = d << s;
        for (int j = 0; j < 2; j++) begin
            lat[j] = 1 + (int'(s) + step_of[j] - 1) / step_of[j];
            fin[j] = 1'b0;
        end
        @(negedge clk);
        for (int j = 0; j < 2; j++)
            check_eq($sformatf("%s.d%0d.irdy0", tag, j), 32'(w_irdy[j]), 32'd1);
        tb_in_valid = 1'b1;
        tb_data_in  = d;
        tb_shamt    = s;
        tb_oready   = 2'b00;
        n = 0;
        while (!(fin[0] && fin[1]) && n < 80) begin
            @(negedge clk);
            n++;
            for (int j = 0; j < 2; j++) begin
                if (!fin[j]) begin
                    exp_ov = (n >= lat[j]) && (n <= lat[j] + h);
                    check_eq($sformatf("%s.d%0d.ov.c%0d", tag, j, n),   32'(w_ov[j]),   32'(exp_ov));
                    check_eq($sformatf("%s.d%0d.dout.c%0d", tag, j, n), w_dout[j],      exp_ov ? res : 32'd0);
                    check_eq($sformatf("%s.d%0d.irdy.c%0d", tag, j, n), 32'(w_irdy[j]), 32'(n > lat[j] + h));
                    check_eq($sformatf("%s.d%0d.busy.c%0d", tag, j, n), 32'(w_busy[j]), 32'(n <= lat[j] + h));
                    if (n > lat[j] + h) fin[j] = 1'b1;
                    tb_oready[j] = (n >= lat[j] + h);
                end
            end
            tb_in_valid = 1'b0;
            tb_data_in  = $urandom;
            tb_shamt    = 5'($urandom);
        end
        if (!(fin[0] && fin[1]))
            check_eq($sformatf("%s.timeout", tag), 32'd0, 32'd1);
    endtask

    // Accept a request on both instances and leave them mid-operation.
    task automatic start_op(input logic [31:0] d, input logic [4:0] s);
        @(negedge clk);
        tb_in_valid = 1'b1;
        tb_data_in  = d;
        tb_shamt    = s;
        tb_oready   = 2'b00;
        @(negedge clk);
        tb_in_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        tb_in_valid = 1'b0;
        tb_data_in  = '0;
        tb_shamt    = '0;
        tb_flush    = 1'b0;
        tb_oready   = 2'b00;
        #3;
        check_idle("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op("msb",   32'h0000_0001, 5'd31, 0);
        run_op("zero",  32'hDEAD_BEEF, 5'd0,  0);
        run_op("step4", 32'hF000_000F, 5'd6,  0);
        run_op("bp",    32'h0000_0001, 5'd3,  5);

        // Flush in cycle 2 of a long shift.
        start_op(32'h1234_5678, 5'd20);
        for (int j = 0; j < 2; j++)
            check_eq($sformatf("fl.d%0d.ov.c1", j), 32'(w_ov[j]), 32'd0);
        @(negedge clk);
        for (int j = 0; j < 2; j++)
            check_eq($sformatf("fl.d%0d.ov.c2", j), 32'(w_ov[j]), 32'd0);
        tb_flush = 1'b1;
        @(negedge clk);
        tb_flush = 1'b0;
        #1;
        check_idle("fl");
        run_op("after_fl", 32'h0000_0003, 5'd1, 0);

        // Flush while the result is presented and being accepted.
        start_op(32'h0000_00A5, 5'd0);
        for (int j = 0; j < 2; j++)
            check_eq($sformatf("fld.d%0d.ov", j), 32'(w_ov[j]), 32'd1);
        tb_flush  = 1'b1;
        tb_oready = 2'b11;
        @(negedge clk);
        tb_flush  = 1'b0;
        tb_oready = 2'b00;
        #1;
        check_idle("fld");

        // Flush beats a simultaneous request.
        @(negedge clk);
        tb_in_valid = 1'b1;
        tb_data_in  = 32'h0000_00FF;
        tb_shamt    = 5'd2;
        tb_flush    = 1'b1;
        @(negedge clk);
        tb_in_valid = 1'b0;
        tb_flush    = 1'b0;
        #1;
        check_idle("fli");

        // Asynchronous reset between clock edges mid-shift.
        start_op(32'hCAFE_F00D, 5'd20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 32'h0000_0001, 5'd4, 0);

        // Randomized requests with random backpressure.
        for (int k = 0; k < 30; k++)
            run_op($sformatf("rnd%0d", k), $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_shift_left_seq
